led_fader: RTL and testbench

//  Downstream of the 8-LED stepping pattern generator. Takes its on/off LED

---
 rtl/led_pkg.sv | 24 ++
 rtl/led_fader_ch.sv | 67 ++++++
 rtl/led_fader.sv | 77 +++++++
 tb/tb_led_fader.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// Package: led_pkg
// Shared constants for the LED fader slice, plus the helper that turns a
// clock rate and fade time into the number of clocks between level steps.
package led_pkg;

    localparam int N_LEDS           = 8;
    localparam int DEFAULT_PWM_BITS = 8;

    // Clocks per one-level brightness step so a full 0->MAX ramp lasts fade_ms.
    // All intermediates are 64-bit so clk_freq*fade_ms cannot overflow.
    function automatic int unsigned step_cycles(input longint unsigned clk_freq,
                                                input longint unsigned fade_ms,
                                                input int unsigned     pwm_bits);
        longint unsigned max_level;
        longint unsigned steps;
        max_level = (64'd1 << pwm_bits) - 64'd1;
        steps     = clk_freq * fade_ms / 64'd1000 / max_level;
        if (steps < 64'd1) begin
            steps = 64'd1;
        end
        return 32'(steps);
    endfunction

endpackage

// File: rtl/led_fader_ch.sv
// Module: led_fader_ch
// One LED channel: brightness level register with a saturating one-step
// ramp toward its on/off target, the level-to-duty mapping and the
// registered PWM compare that drives the pin.
// Build option: define LED_FADER_GAMMA_EN to use a quadratic duty curve
// (duty = level*level >> PWM_BITS); otherwise duty equals level.
module led_fader_ch
    import led_pkg::*;
#(
    parameter int PWM_BITS = DEFAULT_PWM_BITS
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic                tick,
    input  logic                target_on,
    input  logic [PWM_BITS-1:0] pwm_cnt,
    output logic                led_out,
    output logic                off_target
);

    localparam logic [PWM_BITS-1:0] MAX_LEVEL = '1;

    logic [PWM_BITS-1:0] level;
    logic [PWM_BITS-1:0] target;
    logic [PWM_BITS-1:0] duty;

    assign target     = target_on ? MAX_LEVEL : '0;
    assign off_target = (level != target);

`ifdef LED_FADER_GAMMA_EN
    logic [2*PWM_BITS-1:0] level_wide;
    logic [2*PWM_BITS-1:0] level_sq;
    assign level_wide = {{PWM_BITS{1'b0}}, level};
    assign level_sq   = level_wide * level_wide;
    assign duty       = level_sq[2*PWM_BITS-1:PWM_BITS];
`else
    assign duty = level;
`endif

    // Level register: copies the target in bypass, otherwise steps once per tick and stops at the target.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            level <= '0;
        end else if (!enable) begin
            level <= target;
        end else if (tick) begin
            if (level < target) begin
                level <= level + 1'b1;
            end else if (level > target) begin
                level <= level - 1'b1;
            end
        end
    end

    // Pin drive: raw target in bypass; otherwise PWM compare with full level forced solidly on.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            led_out <= 1'b0;
        end else if (!enable) begin
            led_out <= target_on;
        end else begin
            led_out <= (level == MAX_LEVEL) || (duty > pwm_cnt);
        end
    end

endmodule

// File: rtl/led_fader.sv
// Module: led_fader
// Sits between the LED pattern register and the board pins. Each on/off
// change on leds_in fades in or out over FADE_MS instead of switching hard.
// This level owns the fade-tick prescaler, the shared PWM phase counter and
// the busy flag; the per-LED work lives in led_fader_ch.
// Build option: define LED_FADER_GAMMA_EN for a quadratic brightness curve.
module led_fader
    import led_pkg::*;
#(
    parameter int CLK_FREQ = 25_000_000,
    parameter int FADE_MS  = 250,
    parameter int PWM_BITS = DEFAULT_PWM_BITS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic [N_LEDS-1:0] leds_in,
    output logic [N_LEDS-1:0] leds_out,
    output logic              busy
);

    localparam int unsigned STEP_CYCLES = step_cycles(64'(CLK_FREQ), 64'(FADE_MS), PWM_BITS);
    localparam int          PRESC_W     = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(STEP_CYCLES - 1);

    logic [PRESC_W-1:0]  prescaler;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic                fade_tick;
    logic [N_LEDS-1:0]   off_target;

    assign fade_tick = enable && (prescaler == PRESC_LAST);

    // Prescaler: held at zero in bypass so the first tick lands STEP_CYCLES clocks after enable rises.
    always_ff @(posedge clk) begin
        if (!rst_n || !enable) begin
            prescaler <= '0;
        end else if (fade_tick) begin
            prescaler <= '0;
        end else begin
            prescaler <= prescaler + 1'b1;
        end
    end

    // Free-running PWM phase shared by every channel.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
        end
    end

    // Busy: some channel is still away from its target; never set in bypass.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy <= 1'b0;
        end else begin
            busy <= enable && (|off_target);
        end
    end

    for (genvar i = 0; i < N_LEDS; i++) begin : g_ch
        led_fader_ch #(
            .PWM_BITS (PWM_BITS)
        ) u_ch (
            .clk        (clk),
            .rst_n      (rst_n),
            .enable     (enable),
            .tick       (fade_tick),
            .target_on  (leds_in[i]),
            .pwm_cnt    (pwm_cnt),
            .led_out    (leds_out[i]),
            .off_target (off_target[i])
        );
    end

endmodule

// File: tb/tb_led_fader.sv
// Testbench: tb_led_fader
// Drives led_fader with CLK_FREQ=1000, FADE_MS=255, PWM_BITS=8 (one fade
// step per clock) and compares it against a behavioural brightness model.
// Define LED_FADER_GAMMA_EN here as for the RTL to check the quadratic curve.
module tb_led_fader;

    localparam int MAXL     = 255;
    localparam int STEP_RAW = 1000 * 255 / 1000 / 255;
    localparam int STEP     = (STEP_RAW < 1) ? 1 : STEP_RAW;
`ifdef LED_FADER_GAMMA_EN
    localparam int EXP_ONES = 64;
`else
    localparam int EXP_ONES = 128;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic [7:0] leds_in;
    logic [7:0] leds_out;
    logic       busy;

    int n_total = 0;
    int n_bad   = 0;

    int         m_level [8];
    int         m_presc = 0;
    int         m_pwm   = 0;
    logic [7:0] m_out   = 8'h00;
    logic       m_busy  = 1'b0;
    bit         m_hold  = 1'b0;

    always #5 clk = ~clk;

    led_fader #(
        .CLK_FREQ (1000),
        .FADE_MS  (255),
        .PWM_BITS (8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable   (enable),
        .leds_in  (leds_in),
        .leds_out (leds_out),
        .busy     (busy)
    );

    // Brightness-to-duty curve expressed directly as a fraction of 256.
    function automatic int duty_of(input int lvl);
`ifdef LED_FADER_GAMMA_EN
        return (lvl * lvl) / 256;
`else
        return lvl;
`endif
    endfunction

    // Reference model: each LED's brightness walks one unit per fade tick toward 0 or 255.
    always @(posedge clk) begin
        logic [7:0] nout;
        logic       nbusy;
        bit         wrap;
        bit         tick;
        int         tgt;
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) m_level[i] = 0;
            m_presc = 0;
            m_pwm   = 0;
            m_out   = 8'h00;
            m_busy  = 1'b0;
        end else begin
            wrap  = enable && (m_presc == STEP - 1);
            tick  = wrap && !m_hold;
            nbusy = 1'b0;
            nout  = 8'h00;
            for (int i = 0; i < 8; i++) begin
                tgt = leds_in[i] ? MAXL : 0;
                if (enable)
                    nout[i] = (m_level[i] == MAXL) || (duty_of(m_level[i]) > m_pwm);
                else
                    nout[i] = leds_in[i];
                if (enable && (m_level[i] != tgt)) nbusy = 1'b1;
                if (!enable)                             m_level[i] = tgt;
                else if (tick && (m_level[i] < tgt))     m_level[i] = m_level[i] + 1;
                else if (tick && (m_level[i] > tgt))     m_level[i] = m_level[i] - 1;
            end
            m_out   = nout;
            m_busy  = nbusy;
            m_presc = (!enable || wrap) ? 0 : m_presc + 1;
            m_pwm   = (m_pwm + 1) % 256;
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        enable  = 1'b1;
        leds_in = 8'hFF;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_total++;
            if (leds_out !== 8'h00 || busy !== 1'b0) begin
                n_bad++;
                $display("[TB] FAIL reset_hold: leds_out=%h busy=%b, want 00/0", leds_out, busy);
            end
        end
        rst_n = 1'b1;
        #1;
        n_total++;
        if (leds_out !== 8'h00 || busy !== 1'b0) begin
            n_bad++;
            $display("[TB] FAIL reset_release: leds_out=%h busy=%b, want 00/0", leds_out, busy);
        end
        @(negedge clk);
        n_total++;
        if (leds_out !== 8'h00 || busy !== m_busy) begin
            n_bad++;
            $display("[TB] FAIL reset_first: leds_out=%h busy=%b, want 00/%b", leds_out, busy, m_busy);
        end
    endtask

    task automatic test_fade_up();
        bit rise;
        int cnt;
        int errs;
        do_reset();
        enable  = 1'b1;
        leds_in = 8'h00;
        repeat (3) @(negedge clk);
        leds_in = 8'h01;
        rise = 1'b0;
        for (int k = 0; k < 2 && !rise; k++) begin
            @(negedge clk);
            if (busy === 1'b1) rise = 1'b1;
        end
        n_total++;
        if (!rise) begin
            n_bad++;
            $display("[TB] FAIL fade_up_busy_rise: busy=%b, want 1 within 2 cycles", busy);
        end
        cnt = rise ? 1 : 0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            n_total++;
            if (leds_out !== m_out || busy !== m_busy) begin
                n_bad++;
                $display("[TB] FAIL fade_up_model: leds_out=%h busy=%b, want %h/%b", leds_out, busy, m_out, m_busy);
            end
            if (busy !== 1'b1) break;
            cnt++;
        end
        n_total++;
        if (cnt != 255) begin
            n_bad++;
            $display("[TB] FAIL fade_up_ticks: busy cycles=%0d, want 255", cnt);
        end
        errs = 0;
        for (int k = 0; k < 260; k++) begin
            if (leds_out[0] !== 1'b1) errs++;
            @(negedge clk);
        end
        n_total++;
        if (errs != 0) begin
            n_bad++;
            $display("[TB] FAIL fade_up_full_on: off cycles=%0d, want 0", errs);
        end
    endtask

    task automatic test_reverse();
        int cnt;
        int errs;
        do_reset();
        enable  = 1'b1;
        leds_in = 8'h00;
        repeat (2) @(negedge clk);
        leds_in = 8'h01;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            n_total++;
            if (leds_out !== m_out || busy !== m_busy) begin
                n_bad++;
                $display("[TB] FAIL reverse_up_model: leds_out=%h busy=%b, want %h/%b", leds_out, busy, m_out, m_busy);
            end
        end
        leds_in = 8'h00;
        cnt = 0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            n_total++;
            if (leds_out !== m_out || busy !== m_busy) begin
                n_bad++;
                $display("[TB] FAIL reverse_down_model: leds_out=%h busy=%b, want %h/%b", leds_out, busy, m_out, m_busy);
            end
            if (busy !== 1'b1) break;
            cnt++;
        end
        n_total++;
        if (cnt != 100) begin
            n_bad++;
            $display("[TB] FAIL reverse_ticks: busy cycles=%0d, want 100", cnt);
        end
        errs = 0;
        for (int k = 0; k < 256; k++) begin
            if (leds_out[0] !== 1'b0) errs++;
            @(negedge clk);
        end
        n_total++;
        if (errs != 0) begin
            n_bad++;
            $display("[TB] FAIL reverse_off: on cycles=%0d, want 0", errs);
        end
    endtask

    task automatic test_bypass();
        enable  = 1'b0;
        leds_in = 8'hA5;
        @(negedge clk);
        n_total++;
        if (leds_out !== 8'hA5 || busy !== 1'b0) begin
            n_bad++;
            $display("[TB] FAIL bypass: leds_out=%h busy=%b, want a5/0", leds_out, busy);
        end
        enable = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            n_total++;
            if (leds_out !== 8'hA5 || busy !== 1'b0) begin
                n_bad++;
                $display("[TB] FAIL bypass_resume: leds_out=%h busy=%b, want a5/0", leds_out, busy);
            end
        end
    endtask

    task automatic test_reset_mid();
        int cnt;
        do_reset();
        enable  = 1'b1;
        leds_in = 8'h00;
        @(negedge clk);
        leds_in = 8'h01;
        repeat (50) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        n_total++;
        if (leds_out !== 8'h00 || busy !== 1'b0) begin
            n_bad++;
            $display("[TB] FAIL reset_mid: leds_out=%h busy=%b, want 00/0", leds_out, busy);
        end
        rst_n = 1'b1;
        cnt = 0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            n_total++;
            if (leds_out !== m_out || busy !== m_busy) begin
                n_bad++;
                $display("[TB] FAIL reset_mid_model: leds_out=%h busy=%b, want %h/%b", leds_out, busy, m_out, m_busy);
            end
            if (busy !== 1'b1) break;
            cnt++;
        end
        n_total++;
        if (cnt != 255) begin
            n_bad++;
            $display("[TB] FAIL reset_mid_restart: busy cycles=%0d, want 255", cnt);
        end
    endtask

    task automatic test_duty();
        int ones;
        do_reset();
        enable  = 1'b1;
        leds_in = 8'h00;
        repeat (2) @(negedge clk);
        leds_in = 8'h01;
        repeat (128) @(negedge clk);
        force dut.fade_tick = 1'b0;
        m_hold = 1'b1;
        ones = 0;
        for (int k = 0; k < 256; k++) begin
            @(negedge clk);
            if (leds_out[0] === 1'b1) ones++;
            n_total++;
            if (leds_out !== m_out || busy !== m_busy) begin
                n_bad++;
                $display("[TB] FAIL duty_model: leds_out=%h busy=%b, want %h/%b", leds_out, busy, m_out, m_busy);
            end
        end
        n_total++;
        if (ones != EXP_ONES) begin
            n_bad++;
            $display("[TB] FAIL duty_128: on cycles=%0d, want %0d", ones, EXP_ONES);
        end
        release dut.fade_tick;
        m_hold = 1'b0;
    endtask

    task automatic test_random();
        do_reset();
        enable  = 1'b1;
        leds_in = 8'($urandom);
        for (int k = 0; k < 1500; k++) begin
            @(negedge clk);
            n_total++;
            if (leds_out !== m_out || busy !== m_busy) begin
                n_bad++;
                $display("[TB] FAIL random_model: cycle=%0d leds_out=%h busy=%b, want %h/%b", k, leds_out, busy, m_out, m_busy);
            end
            if ($urandom_range(0, 29) == 0)  leds_in = 8'($urandom);
            if ($urandom_range(0, 149) == 0) enable = ~enable;
            rst_n = ($urandom_range(0, 399) != 0);
        end
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n   = 1'b0;
        enable  = 1'b0;
        leds_in = 8'h00;
        for (int i = 0; i < 8; i++) m_level[i] = 0;
        test_reset();
        test_fade_up();
        test_reverse();
        test_bypass();
        test_reset_mid();
        test_duty();
        test_random();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
